// File: rtl/aq_cp0_rst_inv_ctrl.sv
// CP0 responder for the IFU reset-invalidation request: walks I-cache, D-cache and TLB
// invalidation handshakes, then sweeps every BHT entry, and reports done to the IFU.
module aq_cp0_rst_inv_ctrl #(
    parameter int unsigned BHT_IDX_W = 4
) (
    input  logic                 vec_sm_clk,
    input  logic                 cpurst_b,
    input  logic                 ifu_cp0_rst_inv_req,
    input  logic                 cp0_inv_skip_icache,
    input  logic                 cp0_inv_skip_dcache,
    input  logic                 cp0_inv_skip_tlb,
    input  logic                 icache_cp0_inv_ack,
    input  logic                 dcache_cp0_inv_ack,
    input  logic                 mmu_cp0_inv_ack,
    output logic                 cp0_icache_inv_req,
    output logic                 cp0_dcache_inv_req,
    output logic                 cp0_mmu_inv_req,
    output logic                 cp0_bht_inv_vld,
    output logic [BHT_IDX_W-1:0] cp0_bht_inv_idx,
    output logic                 cp0_ifu_rst_inv_done,
    output logic                 cp0_rst_inv_busy,
    output logic [2:0]           cp0_rst_inv_cur_st
);

    typedef enum logic [2:0] {
        StIdle   = 3'b000,
        StIcache = 3'b001,
        StDcache = 3'b010,
        StTlb    = 3'b011,
        StBht    = 3'b100,
        StDone   = 3'b101
    } state_e;

    localparam logic [BHT_IDX_W-1:0] CntOne = {{(BHT_IDX_W-1){1'b0}}, 1'b1};

    // State is held as raw bits so unused codes stay representable and recoverable.
    logic [2:0]           state_q, state_d;
    logic [2:0]           skip_q, skip_d;  // {tlb, dcache, icache}
    logic [BHT_IDX_W-1:0] cnt_q, cnt_d;

    // First non-skipped step strictly after cur; BHT is never skipped.
    function automatic logic [2:0] next_step(input logic [2:0] cur, input logic [2:0] skip);
        logic [2:0] nxt;
        nxt = StBht;
        if (cur == StIdle && !skip[0]) begin
            nxt = StIcache;
        end else if ((cur == StIdle || cur == StIcache) && !skip[1]) begin
            nxt = StDcache;
        end else if (cur != StTlb && !skip[2]) begin
            nxt = StTlb;
        end
        return nxt;
    endfunction

    always_ff @(posedge vec_sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= StIdle;
            skip_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        skip_d               = skip_q;
        cnt_d                = '0;
        cp0_icache_inv_req   = 1'b0;
        cp0_dcache_inv_req   = 1'b0;
        cp0_mmu_inv_req      = 1'b0;
        cp0_bht_inv_vld      = 1'b0;
        cp0_ifu_rst_inv_done = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                cp0_ifu_rst_inv_done = (state_q == StDone);
                if (ifu_cp0_rst_inv_req) begin
                    skip_d  = {cp0_inv_skip_tlb, cp0_inv_skip_dcache, cp0_inv_skip_icache};
                    state_d = next_step(StIdle, skip_d);
                end
            end
            StIcache: begin
                cp0_icache_inv_req = 1'b1;
                if (icache_cp0_inv_ack) begin
                    state_d = next_step(StIcache, skip_q);
                end
            end
            StDcache: begin
                cp0_dcache_inv_req = 1'b1;
                if (dcache_cp0_inv_ack) begin
                    state_d = next_step(StDcache, skip_q);
                end
            end
            StTlb: begin
                cp0_mmu_inv_req = 1'b1;
                if (mmu_cp0_inv_ack) begin
                    state_d = next_step(StTlb, skip_q);
                end
            end
            StBht: begin
                cp0_bht_inv_vld = 1'b1;
                cnt_d           = cnt_q + CntOne;
                if (&cnt_q) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign cp0_bht_inv_idx    = cnt_q;
    assign cp0_rst_inv_busy   = (state_q != StIdle) && (state_q != StDone);
    assign cp0_rst_inv_cur_st = state_q;

endmodule

// File: tb/tb_aq_cp0_rst_inv_ctrl.sv
// Directed bench for aq_cp0_rst_inv_ctrl: handshake order, skips, ack delay, reset,
// restart from done and illegal-state recovery, all against hand-computed cycle counts.
module tb_aq_cp0_rst_inv_ctrl;

    localparam int unsigned IdxW = 4;
    localparam int          NEnt = 1 << IdxW;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            ifu_req, skip_ic, skip_dc, skip_tlb;
    logic            ic_ack, dc_ack, mmu_ack;
    logic            ic_req, dc_req, mmu_req, vld, done, busy;
    logic [IdxW-1:0] idx;
    logic [2:0]      cur_st;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aq_cp0_rst_inv_ctrl #(.BHT_IDX_W(IdxW)) dut (
        .vec_sm_clk           (clk),
        .cpurst_b             (rst_b),
        .ifu_cp0_rst_inv_req  (ifu_req),
        .cp0_inv_skip_icache  (skip_ic),
        .cp0_inv_skip_dcache  (skip_dc),
        .cp0_inv_skip_tlb     (skip_tlb),
        .icache_cp0_inv_ack   (ic_ack),
        .dcache_cp0_inv_ack   (dc_ack),
        .mmu_cp0_inv_ack      (mmu_ack),
        .cp0_icache_inv_req   (ic_req),
        .cp0_dcache_inv_req   (dc_req),
        .cp0_mmu_inv_req      (mmu_req),
        .cp0_bht_inv_vld      (vld),
        .cp0_bht_inv_idx      (idx),
        .cp0_ifu_rst_inv_done (done),
        .cp0_rst_inv_busy     (busy),
        .cp0_rst_inv_cur_st   (cur_st)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // exp bit order: {icache_req, dcache_req, mmu_req, bht_vld, done, busy}
    task automatic chk_outs(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, ic_req, dc_req, mmu_req, vld, done, busy}, {26'd0, exp});
    endtask

    task automatic clr_inputs();
        ifu_req  = 1'b0;
        skip_ic  = 1'b0;
        skip_dc  = 1'b0;
        skip_tlb = 1'b0;
        ic_ack   = 1'b0;
        dc_ack   = 1'b0;
        mmu_ack  = 1'b0;
    endtask

    // Pulse req for one edge; on return the bench sits in cycle 1 of the sequence.
    task automatic send_req(input logic s_ic, input logic s_dc, input logic s_tlb);
        ifu_req  = 1'b1;
        skip_ic  = s_ic;
        skip_dc  = s_dc;
        skip_tlb = s_tlb;
        step();
        clr_inputs();
        start_cyc = cyc;
    endtask

    function automatic int cyc_now();
        return cyc - start_cyc + 1;
    endfunction

    // which: 0 icache, 1 dcache, 2 mmu. Optionally pulse a (to be ignored) req mid-wait.
    task automatic hs(input int which, input int wait_cyc, input int pulse_at);
        logic [2:0] r;
        r = 3'b100 >> which;
        chk_outs($sformatf("hs%0d_enter", which), {r, 3'b001});
        for (int i = 0; i < wait_cyc; i++) begin
            if (i == pulse_at) begin
                ifu_req  = 1'b1;
                skip_ic  = 1'b1;
                skip_dc  = 1'b1;
                skip_tlb = 1'b1;
            end
            step();
            clr_inputs();
            chk_outs($sformatf("hs%0d_wait", which), {r, 3'b001});
        end
        ic_ack  = (which == 0);
        dc_ack  = (which == 1);
        mmu_ack = (which == 2);
        step();
        clr_inputs();
    endtask

    task automatic bht_sweep(input bit inject);
        for (int i = 0; i < NEnt; i++) begin
            chk_outs("bht_outs", 6'b000101);
            check("bht_idx", {28'd0, idx}, i);
            if (inject && (i == 3 || i == 9)) begin
                ic_ack  = 1'b1;
                mmu_ack = 1'b1;
            end
            step();
            clr_inputs();
        end
    endtask

    initial begin
        clr_inputs();
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        #1;
        chk_outs("reset_outs", 6'b000000);
        check("reset_st", {29'd0, cur_st}, 0);
        check("reset_idx", {28'd0, idx}, 0);
        step();
        step();
        rst_b = 1'b1;
        step();
        chk_outs("idle_after_reset", 6'b000000);

        // No skips, each ack one cycle after its req rises.
        send_req(1'b0, 1'b0, 1'b0);
        check("t1_cyc1_icache", {29'd0, cur_st}, 1);
        hs(0, 1, -1);
        hs(1, 1, -1);
        hs(2, 1, -1);
        bht_sweep(1'b0);
        chk_outs("t1_done", 6'b000010);
        check("t1_done_cycle", cyc_now(), 23);
        check("t1_done_st", {29'd0, cur_st}, 5);
        step();
        step();
        step();
        chk_outs("t1_done_hold", 6'b000010);

        // Restart from done, skip icache and tlb; stray acks during the sweep.
        send_req(1'b1, 1'b0, 1'b1);
        hs(1, 1, -1);
        bht_sweep(1'b1);
        chk_outs("t2_done", 6'b000010);
        check("t2_done_cycle", cyc_now(), 19);

        // Immediate acks: done at cycle 20.
        send_req(1'b0, 1'b0, 1'b0);
        hs(0, 0, -1);
        hs(1, 0, -1);
        hs(2, 0, -1);
        bht_sweep(1'b0);
        chk_outs("t3_done", 6'b000010);
        check("t3_done_cycle", cyc_now(), 20);

        // Dcache ack held off 50 cycles, a req with all skips pulsed mid-wait is ignored.
        send_req(1'b0, 1'b0, 1'b0);
        hs(0, 0, -1);
        hs(1, 50, 20);
        check("t4_tlb_still_entered", {29'd0, cur_st}, 3);
        hs(2, 0, -1);
        bht_sweep(1'b0);
        chk_outs("t4_done", 6'b000010);
        check("t4_done_cycle", cyc_now(), 70);

        // Reset at idx 7 of the sweep.
        send_req(1'b0, 1'b0, 1'b0);
        hs(0, 0, -1);
        hs(1, 0, -1);
        hs(2, 0, -1);
        for (int i = 0; i < 7; i++) step();
        check("t5_idx_before_rst", {28'd0, idx}, 7);
        rst_b = 1'b0;
        #1;
        chk_outs("t5_rst_outs", 6'b000000);
        check("t5_rst_st", {29'd0, cur_st}, 0);
        check("t5_rst_idx", {28'd0, idx}, 0);
        step();
        step();
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk_outs("t5_quiet_after_rst", 6'b000000);
        check("t5_quiet_st", {29'd0, cur_st}, 0);

        // All skips: straight to the sweep, then restart from done.
        send_req(1'b1, 1'b1, 1'b1);
        bht_sweep(1'b0);
        chk_outs("t6_done_a", 6'b000010);
        check("t6_done_a_cycle", cyc_now(), 17);
        send_req(1'b1, 1'b1, 1'b1);
        bht_sweep(1'b0);
        chk_outs("t6_done_b", 6'b000010);
        check("t6_done_b_cycle", cyc_now(), 17);

        // Illegal state code recovers to idle.
        force dut.state_q = 3'b110;
        #1;
        check("t7_forced_st", {29'd0, cur_st}, 6);
        release dut.state_q;
        step();
        check("t7_recover_st", {29'd0, cur_st}, 0);
        chk_outs("t7_recover_outs", 6'b000000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aq_cp0_rst_inv_ctrl.md
Name: aq_cp0_rst_inv_ctrl

Overview:
- CP0-side responder for the IFU reset-invalidation request: receives the one-cycle request pulse `ifu_cp0_rst_inv_req` from the IFU vector FSM.
- Sequences invalidation of the L1 I-cache, L1 D-cache, MMU TLB (each a req/ack handshake), then the branch history table (internal index sweep).
- Raises `cp0_ifu_rst_inv_done` when all steps finish, which releases the IFU FSM from RESET into WARM_UP.

Parameters:
- BHT_IDX_W, 4, width of BHT index; sweep covers 2^BHT_IDX_W entries (default 16).

Ports:
- vec_sm_clk  in  1  clock, gated; enabled while the IFU vector FSM is non-idle.
- cpurst_b  in  1  reset.
- ifu_cp0_rst_inv_req  in  1  one-cycle invalidation request pulse.
- cp0_inv_skip_icache  in  1  skip I-cache step; sampled with req.
- cp0_inv_skip_dcache  in  1  skip D-cache step; sampled with req.
- cp0_inv_skip_tlb  in  1  skip TLB step; sampled with req.
- icache_cp0_inv_ack  in  1  I-cache invalidation finished, one-cycle pulse.
- dcache_cp0_inv_ack  in  1  D-cache invalidation finished, one-cycle pulse.
- mmu_cp0_inv_ack  in  1  TLB invalidation finished, one-cycle pulse.
- cp0_icache_inv_req  out  1  level request to the I-cache.
- cp0_dcache_inv_req  out  1  level request to the D-cache.
- cp0_mmu_inv_req  out  1  level request to the MMU.
- cp0_bht_inv_vld  out  1  BHT entry clear write enable.
- cp0_bht_inv_idx  out  BHT_IDX_W  BHT entry index being cleared.
- cp0_ifu_rst_inv_done  out  1  invalidation complete (level).
- cp0_rst_inv_busy  out  1  sequence in progress.
- cp0_rst_inv_cur_st  out  3  current FSM state, for debug.

Behaviour:
- Reset: cpurst_b is asynchronous, active-low; the clock is vec_sm_clk. All flops reset; state=IDLE; every output=0; skip latches=0; index counter=0.
- State encoding: IDLE=000, ICACHE=001, DCACHE=010, TLB=011, BHT=100, DONE=101; other codes go to IDLE next cycle.
- IDLE:
  - `ifu_cp0_rst_inv_req` sampled high → latch the three skip bits.
  - Go to the first non-skipped step in the order ICACHE, DCACHE, TLB, BHT.
  - BHT is never skipped.
- ICACHE / DCACHE / TLB:
  - The matching `*_inv_req` equals state decode: high from the first cycle in the state until the cycle its ack is sampled, inclusive.
  - On ack sampled high, advance to the next non-skipped step.
  - A step with its skip bit latched is never entered; its req never asserts.
  - An ack received outside its matching state is ignored.
  - No timeout: the block waits indefinitely for each ack.
- BHT:
  - `cp0_bht_inv_vld`=1 every cycle in BHT; `cp0_bht_inv_idx`=counter.
  - Counter increments by 1 per cycle and wraps to 0.
  - When idx = all-ones is issued, next state=DONE.
  - BHT occupies exactly 2^BHT_IDX_W cycles.
- DONE:
  - `cp0_ifu_rst_inv_done`=1 and held until a new req.
  - A req in DONE restarts: done drops the cycle after the req, skips re-latch, and the sequence begins again.
- `cp0_rst_inv_busy` = state not IDLE and not DONE.
- A req arriving while busy is ignored: no restart, latched skips unchanged.
- At most one `*_inv_req` is high in any cycle.
- Reset asserted mid-sequence: all outputs drop asynchronously to 0; no done is produced until a fresh req.
- Latency with no skips and single-cycle acks (req sampled at edge 0):
  - cp0_icache_inv_req high in cycle 1.
  - Done rises 3+ack-wait+2^BHT_IDX_W cycles later.
  - Default with immediate acks: done high at cycle 20.

Test Plan:
- Reset then single req pulse, no skips, each ack returned 1 cycle after its req rises:
  - req order is icache → dcache → mmu, never overlapping;
  - 16 bht_inv_vld cycles with idx 0..15 in order;
  - done rises the cycle after idx=15 and stays high.
- Skip icache and tlb:
  - only dcache req asserts, then the BHT sweep;
  - icache_cp0_inv_ack and mmu_cp0_inv_ack pulses injected during BHT are ignored (sweep stays 16 cycles).
- Delay dcache ack by 50 cycles:
  - dcache req held 50+ cycles, busy=1 throughout;
  - a second ifu_cp0_rst_inv_req mid-wait has no effect.
- Assert cpurst_b=0 during the BHT sweep at idx=7:
  - all outputs 0 immediately, state IDLE;
  - after release, no activity until a new req.
- Req while in DONE with all skips set:
  - done falls, BHT sweep of 16 cycles, done rises again;
  - no icache, dcache or mmu req ever asserts.
- Force an illegal state code (110) → IDLE the next cycle, all outputs 0.
